// File: rtl/vend_fsm_change.sv
// vend_fsm_change: coin-accumulating vending controller with overpayment
// change, cancel/refund and coin rejection.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   coin_valid    one-cycle strobe qualifying coin_value
//   coin_value    coin denomination in units
//   cancel        customer abort, level-sampled (only honoured in COLLECT)
//   change_ready  hopper accepts change_amt this cycle
//   dispense      one-cycle product release pulse
//   change_valid  change/refund offer pending
//   change_amt    units to return, stable while change_valid
//   coin_reject   pulse: the coin presented last cycle was not credited
//   credit        current accumulated credit
//   LED_Yellow    dispensing or returning change
//   LED_Green     machine ready (IDLE)
//
// Every output is either a register or a decode of the state register, so
// there is no combinational input-to-output path.
module vend_fsm_change #(
    parameter int PRICE  = 5,
    parameter int COIN_W = 4,
    parameter int SUM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_value,
    input  logic              cancel,
    input  logic              change_ready,
    output logic              dispense,
    output logic              change_valid,
    output logic [SUM_W-1:0]  change_amt,
    output logic              coin_reject,
    output logic [SUM_W-1:0]  credit,
    output logic              LED_Yellow,
    output logic              LED_Green
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE,
        REFUND
    } state_t;

    localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] credit_nxt, amt_nxt;
    logic             reject_nxt;
    logic [SUM_W:0]   new_sum;
    logic             in_pay, cancel_hit, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            credit      <= '0;
            change_amt  <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            change_amt  <= amt_nxt;
            coin_reject <= reject_nxt;
        end
    end

    always_comb begin
        // One extra bit so an overflowing coin is visible as new_sum[SUM_W].
        new_sum    = {1'b0, credit} + {{(SUM_W + 1 - COIN_W){1'b0}}, coin_value};
        in_pay     = (state == IDLE) || (state == COLLECT);
        // Cancel in COLLECT wins over a coin arriving in the same cycle.
        cancel_hit = (state == COLLECT) && cancel;
        accept     = coin_valid && in_pay && !cancel_hit &&
                     (coin_value != '0) && !new_sum[SUM_W];

        state_nxt  = state;
        credit_nxt = credit;
        amt_nxt    = change_amt;
        reject_nxt = coin_valid && !accept;

        case (state)
            IDLE, COLLECT: begin
                if (cancel_hit) begin
                    state_nxt = REFUND;
                    amt_nxt   = credit;
                end else if (accept) begin
                    credit_nxt = new_sum[SUM_W-1:0];
                    if (new_sum >= {1'b0, PRICE_S}) begin
                        state_nxt = DISPENSE;
                        // No borrow: new_sum fits in SUM_W bits and is >= PRICE.
                        amt_nxt   = new_sum[SUM_W-1:0] - PRICE_S;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            DISPENSE: begin
                credit_nxt = '0;
                state_nxt  = (change_amt != '0) ? CHANGE : IDLE;
            end
            CHANGE, REFUND: begin
                // change_valid is always high here, so change_ready alone
                // completes the handshake.
                if (change_ready) begin
                    state_nxt  = IDLE;
                    amt_nxt    = '0;
                    credit_nxt = '0;
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
                amt_nxt    = '0;
            end
        endcase
    end

    assign dispense     = (state == DISPENSE);
    assign change_valid = (state == CHANGE) || (state == REFUND);
    assign LED_Yellow   = (state == DISPENSE) || (state == CHANGE) || (state == REFUND);
    assign LED_Green    = (state == IDLE);

endmodule

// File: tb/tb_vend_fsm_change.sv
// Directed bench for vend_fsm_change: one instance at PRICE=5/SUM_W=8, a
// second at PRICE=15/SUM_W=4 for the exact-fit and overflow cases.
module tb_vend_fsm_change;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    int         checks = 0;
    int         errors = 0;

    // Instance A: PRICE=5, SUM_W=8
    logic       a_coin_valid = 1'b0;
    logic [3:0] a_coin_value = '0;
    logic       a_cancel = 1'b0;
    logic       a_change_ready = 1'b0;
    logic       a_dispense, a_change_valid, a_coin_reject, a_led_y, a_led_g;
    logic [7:0] a_change_amt, a_credit;

    // Instance B: PRICE=15, SUM_W=4
    logic       b_coin_valid = 1'b0;
    logic [3:0] b_coin_value = '0;
    logic       b_change_ready = 1'b0;
    logic       b_dispense, b_change_valid, b_coin_reject, b_led_y, b_led_g;
    logic [3:0] b_change_amt, b_credit;

    always #5 clk = ~clk;

    vend_fsm_change #(.PRICE(5), .COIN_W(4), .SUM_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .coin_valid(a_coin_valid), .coin_value(a_coin_value),
        .cancel(a_cancel), .change_ready(a_change_ready),
        .dispense(a_dispense), .change_valid(a_change_valid),
        .change_amt(a_change_amt), .coin_reject(a_coin_reject),
        .credit(a_credit), .LED_Yellow(a_led_y), .LED_Green(a_led_g)
    );

    vend_fsm_change #(.PRICE(15), .COIN_W(4), .SUM_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .coin_valid(b_coin_valid), .coin_value(b_coin_value),
        .cancel(1'b0), .change_ready(b_change_ready),
        .dispense(b_dispense), .change_valid(b_change_valid),
        .change_amt(b_change_amt), .coin_reject(b_coin_reject),
        .credit(b_credit), .LED_Yellow(b_led_y), .LED_Green(b_led_g)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_coin(input logic [3:0] v);
        a_coin_valid = 1'b1;
        a_coin_value = v;
        step();
        a_coin_valid = 1'b0;
        a_coin_value = '0;
    endtask

    task automatic b_coin(input logic [3:0] v);
        b_coin_valid = 1'b1;
        b_coin_value = v;
        step();
        b_coin_valid = 1'b0;
        b_coin_value = '0;
    endtask

    task automatic a_idle_chk(input string tag);
        chk({tag, "_grn"}, 32'(a_led_g), 1);
        chk({tag, "_cv"}, 32'(a_change_valid), 0);
        chk({tag, "_cred"}, 32'(a_credit), 0);
    endtask

    initial begin
        // ---- reset state
        #2;
        chk("rst_cred", 32'(a_credit), 0);
        chk("rst_amt", 32'(a_change_amt), 0);
        chk("rst_disp", 32'(a_dispense), 0);
        chk("rst_cv", 32'(a_change_valid), 0);
        chk("rst_rej", 32'(a_coin_reject), 0);
        chk("rst_yel", 32'(a_led_y), 0);
        chk("rst_grn", 32'(a_led_g), 1);
        #10 rst = 1'b1;
        step();

        // ---- exact payment 2,2,1
        a_coin(4'd2);
        chk("t1_c2", 32'(a_credit), 2);
        chk("t1_grn", 32'(a_led_g), 0);
        a_coin(4'd2);
        chk("t1_c4", 32'(a_credit), 4);
        chk("t1_nodisp", 32'(a_dispense), 0);
        a_coin(4'd1);
        chk("t1_c5", 32'(a_credit), 5);
        chk("t1_disp", 32'(a_dispense), 1);
        chk("t1_yel", 32'(a_led_y), 1);
        chk("t1_cv0", 32'(a_change_valid), 0);
        step();
        chk("t1_disp_end", 32'(a_dispense), 0);
        a_idle_chk("t1_idle");

        // ---- overpay 2,5 -> change 2, held with change_ready=0
        a_coin(4'd2);
        a_coin(4'd5);
        chk("t2_disp", 32'(a_dispense), 1);
        chk("t2_cv_disp", 32'(a_change_valid), 0);
        chk("t2_amt", 32'(a_change_amt), 2);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_cv", 32'(a_change_valid), 1);
            chk("t2_hold_amt", 32'(a_change_amt), 2);
            chk("t2_hold_cred", 32'(a_credit), 0);
            chk("t2_hold_disp", 32'(a_dispense), 0);
            step();
        end
        // coin during CHANGE is rejected, credit unchanged
        a_coin(4'd3);
        chk("t4_chg_rej", 32'(a_coin_reject), 1);
        chk("t4_chg_cred", 32'(a_credit), 0);
        chk("t4_chg_cv", 32'(a_change_valid), 1);
        a_change_ready = 1'b1;
        step();
        a_change_ready = 1'b0;
        chk("t2_done_amt", 32'(a_change_amt), 0);
        chk("t2_done_rej", 32'(a_coin_reject), 0);
        a_idle_chk("t2_done");

        // ---- cancel refund 1,2
        a_coin(4'd1);
        a_coin(4'd2);
        chk("t3_c3", 32'(a_credit), 3);
        a_cancel = 1'b1;
        step();
        a_cancel = 1'b0;
        chk("t3_cv", 32'(a_change_valid), 1);
        chk("t3_amt", 32'(a_change_amt), 3);
        chk("t3_cred", 32'(a_credit), 3);
        chk("t3_disp", 32'(a_dispense), 0);
        // cancel ignored in REFUND, ready ends it
        a_cancel = 1'b1;
        a_change_ready = 1'b1;
        step();
        a_cancel = 1'b0;
        a_change_ready = 1'b0;
        a_idle_chk("t3_done");

        // ---- coin+cancel same cycle
        a_coin(4'd1);
        a_cancel = 1'b1;
        a_coin(4'd2);
        a_cancel = 1'b0;
        chk("t3b_rej", 32'(a_coin_reject), 1);
        chk("t3b_amt", 32'(a_change_amt), 1);
        chk("t3b_cred", 32'(a_credit), 1);
        chk("t3b_cv", 32'(a_change_valid), 1);
        a_change_ready = 1'b1;
        step();
        a_change_ready = 1'b0;
        a_idle_chk("t3b_done");

        // ---- zero coin in IDLE; cancel ignored in IDLE
        a_cancel = 1'b1;
        a_coin(4'd0);
        a_cancel = 1'b0;
        chk("t4_zero_rej", 32'(a_coin_reject), 1);
        a_idle_chk("t4_zero");
        step();
        chk("t4_rej_pulse", 32'(a_coin_reject), 0);

        // ---- single large coin from IDLE straight to DISPENSE
        a_coin(4'd15);
        chk("t7_disp", 32'(a_dispense), 1);
        chk("t7_amt", 32'(a_change_amt), 10);
        step();
        chk("t7_cv", 32'(a_change_valid), 1);
        chk("t7_amt2", 32'(a_change_amt), 10);
        a_change_ready = 1'b1;
        step();
        a_change_ready = 1'b0;
        a_idle_chk("t7_done");

        // ---- instance B: 8,7 exact 15
        b_coin(4'd8);
        chk("t5_b8", 32'(b_credit), 8);
        b_coin(4'd7);
        chk("t5_disp", 32'(b_dispense), 1);
        chk("t5_amt", 32'(b_change_amt), 0);
        step();
        chk("t5_cv", 32'(b_change_valid), 0);
        chk("t5_grn", 32'(b_led_g), 1);
        chk("t5_cred0", 32'(b_credit), 0);
        // 8,6 then 3 overflows
        b_coin(4'd8);
        b_coin(4'd6);
        chk("t5_b14", 32'(b_credit), 14);
        b_coin(4'd3);
        chk("t5_ovf_rej", 32'(b_coin_reject), 1);
        chk("t5_ovf_cred", 32'(b_credit), 14);
        chk("t5_ovf_disp", 32'(b_dispense), 0);
        b_coin(4'd1);
        chk("t5_fill_disp", 32'(b_dispense), 1);
        chk("t5_fill_rej", 32'(b_coin_reject), 0);
        step();
        chk("t5_fill_grn", 32'(b_led_g), 1);

        // ---- async reset mid-CHANGE
        a_coin(4'd4);
        a_coin(4'd4);
        chk("t6_amt", 32'(a_change_amt), 3);
        step();
        chk("t6_cv_pre", 32'(a_change_valid), 1);
        #3 rst = 1'b0;
        #1;
        chk("t6_cv", 32'(a_change_valid), 0);
        chk("t6_amt0", 32'(a_change_amt), 0);
        chk("t6_cred", 32'(a_credit), 0);
        chk("t6_yel", 32'(a_led_y), 0);
        chk("t6_grn", 32'(a_led_g), 1);
        chk("t6_disp", 32'(a_dispense), 0);
        #2 rst = 1'b1;
        step();
        a_coin(4'd5);
        chk("t6_vend", 32'(a_dispense), 1);
        chk("t6_vcred", 32'(a_credit), 5);
        step();
        a_idle_chk("t6_after");
        chk("t6_after_disp", 32'(a_dispense), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
